// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage: PC width, reset PC,
// NOP encoding, fetch FSM state encoding and the buffered fetch entry.
package if_stage_pkg;

  localparam int              PC_W         = 64;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [31:0]     NOP_INST     = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's redirect, decode and instruction-memory signals.
// master = the fetch stage, slave = its environment (execute, decode, memory).
interface if_stage_if;
  import if_stage_pkg::*;

  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            id_ready;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [PC_W-1:0] inst_addr;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [PC_W-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    input  redirect_valid, redirect_pc, id_ready,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst, inst_addr,
    output imem_req_valid, imem_req_addr
  );

  modport slave (
    output redirect_valid, redirect_pc, id_ready,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst, inst_addr,
    input  imem_req_valid, imem_req_addr
  );

endinterface

// File: rtl/if_fifo.sv
// Synchronous instruction buffer of {pc, inst} entries. Flush beats push and pop;
// push when full and pop when empty are ignored.
module if_fifo
  import if_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push & (count_r != CNT_W'(DEPTH));
  assign pop_ok_s  = pop & (count_r != {CNT_W{1'b0}});
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign full      = (count_r == CNT_W'(DEPTH));

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{pc: 64'h0, inst: 32'h0};
      end
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding fetches and buffers
// returned instructions for decode. Define IF_RSP_BYPASS_EN to forward responses straight to decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int              FIFO_DEPTH = 2
) (
  input logic        clk,
  input logic        rst_n,
  if_stage_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t     state_r;
  logic [PC_W-1:0]  pc_r;
  logic [PC_W-1:0]  rsp_pc_r;
  logic [PC_W-1:0]  req_addr_r;
  logic             req_valid_r;
  logic             outstanding_r;
  logic             kill_r;

  logic [CNT_W-1:0] fifo_count_s;
  logic             fifo_empty_s;
  logic             fifo_full_s;
  fetch_entry_t     head_s;
  fetch_entry_t     push_entry_s;
  logic             push_s;
  logic             pop_s;
  logic             flush_s;
  logic             handshake_s;
  logic             rsp_fire_s;
  logic             bypass_s;
  logic             resv_ok_s;
  logic             space_ok_s;
  logic [CNT_W:0]   resv_s;
  logic [CNT_W:0]   cnt_next_s;
  logic [PC_W-1:0]  redirect_tgt_s;

  if_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_s),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  // FIFO control and reservation: a request is only issued if its response is guaranteed a slot.
  always_comb begin
    redirect_tgt_s = align_pc(bus.redirect_pc);
    handshake_s    = req_valid_r & bus.imem_req_ready;
    rsp_fire_s     = outstanding_r & bus.imem_rsp_valid;
    flush_s        = bus.redirect_valid;
    bypass_s       = 1'b0;
`ifdef IF_RSP_BYPASS_EN
    bypass_s       = fifo_empty_s & ~kill_r & ~bus.redirect_valid & rsp_fire_s;
`endif
    push_entry_s   = '{pc: rsp_pc_r, inst: bus.imem_rsp_data};
    push_s         = rsp_fire_s & ~kill_r & ~bus.redirect_valid & ~(bypass_s & bus.id_ready);
    pop_s          = ~fifo_empty_s & bus.id_ready & ~bus.redirect_valid;
    resv_s         = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, outstanding_r};
    resv_ok_s      = ~fifo_full_s & (resv_s < (CNT_W+1)'(FIFO_DEPTH));
    cnt_next_s     = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, push_s} - {{CNT_W{1'b0}}, pop_s};
    space_ok_s     = (cnt_next_s < (CNT_W+1)'(FIFO_DEPTH));
  end

  // Decode-facing outputs; an invalid slot always shows a NOP so decode never sees opcode 0.
  always_comb begin
    if (bypass_s) begin
      bus.inst_valid = 1'b1;
      bus.inst       = bus.imem_rsp_data;
      bus.inst_addr  = rsp_pc_r;
    end else if (!fifo_empty_s) begin
      bus.inst_valid = 1'b1;
      bus.inst       = head_s.inst;
      bus.inst_addr  = head_s.pc;
    end else begin
      bus.inst_valid = 1'b0;
      bus.inst       = NOP_INST;
      bus.inst_addr  = {PC_W{1'b0}};
    end
  end

  assign bus.imem_req_valid = req_valid_r;
  assign bus.imem_req_addr  = req_addr_r;

  // Fetch FSM; a redirect overrides everything, and kill marks an in-flight response as stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      pc_r          <= RESET_PC;
      rsp_pc_r      <= {PC_W{1'b0}};
      req_addr_r    <= {PC_W{1'b0}};
      req_valid_r   <= 1'b0;
      outstanding_r <= 1'b0;
      kill_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.redirect_valid) begin
            pc_r        <= redirect_tgt_s;
            req_addr_r  <= redirect_tgt_s;
            req_valid_r <= 1'b1;
            state_r     <= ST_REQ;
          end else if (resv_ok_s) begin
            req_addr_r  <= pc_r;
            req_valid_r <= 1'b1;
            state_r     <= ST_REQ;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (handshake_s) begin
            req_valid_r   <= 1'b0;
            outstanding_r <= 1'b1;
            rsp_pc_r      <= req_addr_r;
            state_r       <= ST_WAIT;
            if (bus.redirect_valid) begin
              pc_r   <= redirect_tgt_s;
              kill_r <= 1'b1;
            end else if (!kill_r) begin
              pc_r   <= pc_r + 64'd4;
            end else begin
              pc_r   <= pc_r;
            end
          end else if (bus.redirect_valid) begin
            // The old request must stay stable until accepted; the new PC is fetched next.
            pc_r   <= redirect_tgt_s;
            kill_r <= 1'b1;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rsp_valid) begin
            outstanding_r <= 1'b0;
            kill_r        <= 1'b0;
            if (bus.redirect_valid) begin
              pc_r        <= redirect_tgt_s;
              req_addr_r  <= redirect_tgt_s;
              req_valid_r <= 1'b1;
              state_r     <= ST_REQ;
            end else if (space_ok_s) begin
              req_addr_r  <= pc_r;
              req_valid_r <= 1'b1;
              state_r     <= ST_REQ;
            end else begin
              state_r     <= ST_IDLE;
            end
          end else if (bus.redirect_valid) begin
            pc_r   <= redirect_tgt_s;
            kill_r <= 1'b1;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          req_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a latency-configurable memory model feeds a scoreboard of
// expected {addr, inst} entries that is checked whenever decode pops an instruction.
module tb_if_stage;
  import if_stage_pkg::*;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  if_stage_if bus ();

  if_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        exp_q[$];
  logic [63:0] req_log[$];
  logic [63:0] pop_log[$];
  int          pop_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_n  = 0;
  int          mem_lat;
  int          mem_cnt;
  int          n_mark;
  logic        mem_busy;
  logic [63:0] mem_addr;
  logic [63:0] rsp_addr;
  logic        model_rsp;
  logic        drop_rsp;

  function automatic logic [31:0] data_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5EED_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, update scoreboard and memory model, drive after posedge.
  task automatic cyc();
    logic hs, rsp, redir, pop;
    exp_t e;
    @(negedge clk);
    hs    = bus.imem_req_valid & bus.imem_req_ready;
    rsp   = bus.imem_rsp_valid & model_rsp;
    redir = bus.redirect_valid;
    pop   = bus.inst_valid & bus.id_ready & ~redir;
    if (!bus.inst_valid) chk("nop_when_invalid", {32'h0, bus.inst}, {32'h0, NOP_INST});
    if (pop) begin
      pop_log.push_back(bus.inst_addr);
      pop_cyc.push_back(cyc_n);
      if (exp_q.size() == 0) begin
        chk("stale_inst_valid", {63'h0, bus.inst_valid}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk("inst_addr", bus.inst_addr, e.addr);
        chk("inst_data", {32'h0, bus.inst}, {32'h0, e.data});
      end
    end
    if (rsp) begin
      if (!drop_rsp && !redir) exp_q.push_back('{addr: rsp_addr, data: bus.imem_rsp_data});
      drop_rsp = 1'b0;
    end
    if (redir) begin
      exp_q.delete();
      if (mem_busy || bus.imem_req_valid) drop_rsp = 1'b1;
    end
    if (hs) begin
      mem_busy = 1'b1;
      mem_addr = bus.imem_req_addr;
      mem_cnt  = mem_lat;
      req_log.push_back(bus.imem_req_addr);
    end
    @(posedge clk);
    #1;
    cyc_n++;
    bus.imem_rsp_valid = 1'b0;
    model_rsp          = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data_of(mem_addr);
        rsp_addr           = mem_addr;
        model_rsp          = 1'b1;
        mem_busy           = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    model_rsp          = 1'b0;
    mem_busy           = 1'b0;
    drop_rsp           = 1'b0;
    exp_q.delete();
    req_log.delete();
    pop_log.delete();
    pop_cyc.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_inst_valid"}, {63'h0, bus.inst_valid}, 64'h0);
    chk({tag, "_inst"}, {32'h0, bus.inst}, {32'h0, NOP_INST});
    chk({tag, "_inst_addr"}, bus.inst_addr, 64'h0);
    chk({tag, "_req_valid"}, {63'h0, bus.imem_req_valid}, 64'h0);
    chk({tag, "_req_addr"}, bus.imem_req_addr, 64'h0);
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    bus.id_ready       = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    mem_lat            = 1;

    // Reset release, streaming fetch with 1-cycle memory
    do_reset();
    bus.id_ready = 1'b1;
    chk_reset_outputs("rst");
    cyc();
    chk("first_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
    chk("first_req_addr", bus.imem_req_addr, 64'h0000_0000_8000_0000);
    repeat (10) cyc();
    chk("t1_req_count_ge3", {63'h0, (req_log.size() >= 3)}, 64'h1);
    chk("t1_req0", req_log[0], 64'h0000_0000_8000_0000);
    chk("t1_req1", req_log[1], 64'h0000_0000_8000_0004);
    chk("t1_req2", req_log[2], 64'h0000_0000_8000_0008);
    chk("t1_pop0", pop_log[0], 64'h0000_0000_8000_0000);
    chk("t1_spacing01", 64'(pop_cyc[1] - pop_cyc[0]), 64'd2);
    chk("t1_spacing12", 64'(pop_cyc[2] - pop_cyc[1]), 64'd2);

    // Decode stalled: exactly two buffered, fetch stops, then in-order drain
    do_reset();
    bus.id_ready = 1'b0;
    repeat (10) cyc();
    chk("t2_req_count", 64'(req_log.size()), 64'd2);
    chk("t2_inst_valid", {63'h0, bus.inst_valid}, 64'h1);
    chk("t2_head_addr", bus.inst_addr, 64'h0000_0000_8000_0000);
    repeat (3) begin
      cyc();
      chk("t2_req_idle", {63'h0, bus.imem_req_valid}, 64'h0);
    end
    bus.id_ready = 1'b1;
    repeat (2) cyc();
    chk("t2_drain0", pop_log[0], 64'h0000_0000_8000_0000);
    chk("t2_drain1", pop_log[1], 64'h0000_0000_8000_0004);

    // Redirect while request is stalled by memory
    do_reset();
    bus.id_ready       = 1'b1;
    bus.imem_req_ready = 1'b0;
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h0000_0000_8000_0100;
    cyc();
    bus.redirect_valid = 1'b0;
    repeat (3) begin
      chk("t3_req_held_valid", {63'h0, bus.imem_req_valid}, 64'h1);
      chk("t3_req_held_addr", bus.imem_req_addr, 64'h0000_0000_8000_0000);
      cyc();
    end
    bus.imem_req_ready = 1'b1;
    repeat (8) cyc();
    chk("t3_req0", req_log[0], 64'h0000_0000_8000_0000);
    chk("t3_req1", req_log[1], 64'h0000_0000_8000_0100);
    chk("t3_pop0", pop_log[0], 64'h0000_0000_8000_0100);

    // Redirect coinciding with the response in WAIT
    do_reset();
    bus.id_ready = 1'b1;
    repeat (2) cyc();
    chk("t4_rsp_present", {63'h0, bus.imem_rsp_valid}, 64'h1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h0000_0000_8000_0200;
    cyc();
    bus.redirect_valid = 1'b0;
    chk("t4_inst_valid", {63'h0, bus.inst_valid}, 64'h0);
    chk("t4_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
    chk("t4_req_addr", bus.imem_req_addr, 64'h0000_0000_8000_0200);
    repeat (4) cyc();
    chk("t4_pop0", pop_log[0], 64'h0000_0000_8000_0200);

    // Asynchronous reset in the middle of a fetch with data buffered
    do_reset();
    bus.id_ready = 1'b0;
    mem_lat      = 3;
    repeat (7) cyc();
    chk("t5_buffered", {63'h0, bus.inst_valid}, 64'h1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("t5_async");
    mem_lat = 1;
    do_reset();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    bus.id_ready       = 1'b1;
    cyc();
    chk("t5_late_rsp_ignored", {63'h0, bus.inst_valid}, 64'h0);
    chk("t5_restart_valid", {63'h0, bus.imem_req_valid}, 64'h1);
    chk("t5_restart_addr", bus.imem_req_addr, 64'h0000_0000_8000_0000);
    repeat (5) cyc();
    chk("t5_pop0", pop_log[0], 64'h0000_0000_8000_0000);

    // PC wrap and misaligned redirect target
    do_reset();
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc();
    bus.redirect_valid = 1'b0;
    chk("t6_req_addr_top", bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    repeat (6) cyc();
    chk("t6_req0", req_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t6_req1_wrap", req_log[1], 64'h0);
    chk("t6_pop0", pop_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t6_pop1", pop_log[1], 64'h0);
    n_mark             = pop_log.size();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h0000_0000_8000_0102;
    cyc();
    bus.redirect_valid = 1'b0;
    repeat (8) cyc();
    chk("t6_aligned_pop", pop_log[n_mark], 64'h0000_0000_8000_0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the decode stage.
- Owns the 64-bit PC and issues single-outstanding fetch requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions in a 2-entry FIFO and presents {inst, inst_addr, inst_valid} to decode.
- Accepts a redirect (taken branch or jump) from execute, which flushes in-flight and buffered fetches.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >= 2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
redirect_valid  in  1  execute requests a PC change this cycle
redirect_pc  in  64  new fetch PC; bits [1:0] are ignored (forced 0)
id_ready  in  1  decode accepts the presented instruction
inst_valid  out  1  inst/inst_addr hold a valid fetched instruction
inst  out  32  instruction to decode
inst_addr  out  64  PC of inst
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  64  fetch address
imem_rsp_valid  in  1  fetch data returned (one per accepted request, latency >= 1)
imem_rsp_data  in  32  fetched instruction

Behaviour:
Clock and reset
- One clock, clk.
- Reset rst_n is asynchronous and active-low.
- While rst_n=0: pc=RESET_PC, state=IDLE, FIFO empty, outstanding=0, kill=0, inst_valid=0, inst=32'h0000_0013 (NOP), inst_addr=0, imem_req_valid=0, imem_req_addr=0.

Output when invalid
- inst is forced to NOP whenever inst_valid=0. Opcode 0 would falsely decode as a load in decode.

Fetch FSM: IDLE, REQ, WAIT
- IDLE -> REQ when (fifo_count + outstanding) < FIFO_DEPTH.
- REQ: imem_req_valid=1, imem_req_addr=req_pc. Once asserted, valid and addr stay stable until imem_req_ready.
  - On handshake: outstanding=1, save rsp_pc=req_pc, pc<=pc+4 (wraps mod 2^64), go to WAIT.
- WAIT: on imem_rsp_valid:
  - If kill=0, push {rsp_pc, imem_rsp_data} into the FIFO; if kill=1, discard the data.
  - Clear outstanding and kill.
  - Go to REQ if space remains, else IDLE.
- Steady-state throughput with 1-cycle memory: one instruction per 2 cycles.
- First imem_req_valid is asserted 1 cycle after rst_n deasserts.

Decode handshake
- inst_valid = FIFO non-empty.
- Pop on inst_valid & id_ready.
- Push and pop in the same cycle leave the count unchanged.
- The FIFO cannot overflow because requests are gated by the reservation rule above.

Redirect (highest priority)
- pc <= {redirect_pc[63:2], 2'b00}.
- FIFO flushed; pop and push in that cycle are ignored; inst_valid=0 next cycle.
- In IDLE: go to REQ with the new pc.
- In REQ without handshake: the request stays asserted with the old address; kill=1 so its response is dropped. The new pc is fetched on the next REQ.
- In REQ with handshake in the same cycle: the request completes, kill=1; pc is not incremented.
- In WAIT without rsp_valid: kill=1.
- In WAIT with rsp_valid in the same cycle: the response is discarded, kill stays 0, next state is REQ.
- Repeated redirects: the last one wins; kill stays 1 until the killed response returns.

Optional Feature:
Macro IF_RSP_BYPASS_EN
- Defined: when the FIFO is empty, kill=0, no redirect, and imem_rsp_valid=1, the response drives inst/inst_addr/inst_valid combinationally in the same cycle.
  - If id_ready=1, it is consumed without entering the FIFO; otherwise it is pushed.
- Undefined: responses always enter the FIFO and are visible no earlier than the cycle after imem_rsp_valid.

Decomposition:
- Shared package/defines: RESET_PC default, NOP_INST 32'h0000_0013, FSM state encodings (IDLE/REQ/WAIT, 2 bits), PC width 64.
- One sub-module, if_fifo: synchronous FIFO_DEPTH-entry FIFO of {64-bit pc, 32-bit inst} with push, pop, flush, count, and empty/full. Flush has priority over push and pop.

Test Plan:
- Reset release with 1-cycle memory and id_ready=1 -> requests to 0x80000000, 0x80000004, 0x80000008; inst_valid with matching inst_addr; one instruction per 2 cycles.
- id_ready=0 for 10 cycles -> exactly 2 instructions buffered, imem_req_valid stays 0 afterwards; releasing id_ready drains in order 0x80000000, 0x80000004.
- imem_req_ready low 3 cycles while redirect_pc=0x80000100 is pulsed in REQ -> addr 0x80000000 held stable; its response is dropped; next request addr=0x80000100; no stale inst_valid.
- Redirect in the same cycle as imem_rsp_valid in WAIT -> response discarded, FIFO empty, next request to the redirect target.
- Assert rst_n=0 mid-WAIT with the FIFO full -> all outputs return to reset values immediately; a late imem_rsp_valid is ignored; fetch restarts at RESET_PC.
- pc=0xFFFF_FFFF_FFFF_FFFC via redirect -> next request address 0x0 (wrap); redirect_pc=0x80000102 -> fetches 0x80000100.
